// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer and flag controller for an asynchronous FIFO.
// Produces the memory write address, the exported Gray write pointer, and the full, almost-full, fill and sticky overflow flags.
module wptr_full_ctrl #(
    parameter int ADDRSIZE    = 4,
    parameter int AFULL_LEVEL = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   rptr,
    input  logic                wovf_clr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                walmost_full,
    output logic [ADDRSIZE:0]   wfill,
    output logic                woverflow
);

    localparam logic [ADDRSIZE:0] AFULL_CMP = (ADDRSIZE+1)'(AFULL_LEVEL);

    logic [ADDRSIZE:0] r_wbin;
    logic [ADDRSIZE:0] r_wptr;
    logic [ADDRSIZE:0] r_wfill;
    logic [ADDRSIZE:0] r_sync [SYNC_STAGES];
    logic              r_wfull;
    logic              r_walmost_full;
    logic              r_woverflow;

    logic              w_push;
    logic [ADDRSIZE:0] w_wbinnext;
    logic [ADDRSIZE:0] w_wgraynext;
    logic [ADDRSIZE:0] w_wq_rptr;
    logic [ADDRSIZE:0] w_rbin_s;
    logic [ADDRSIZE:0] w_fullcmp;
    logic [ADDRSIZE:0] w_diff;

    assign w_push      = winc & ~r_wfull;
    assign w_wbinnext  = r_wbin + {{ADDRSIZE{1'b0}}, w_push};
    assign w_wgraynext = (w_wbinnext >> 1) ^ w_wbinnext;
    assign w_wq_rptr   = r_sync[SYNC_STAGES-1];
    assign w_fullcmp   = {~w_wq_rptr[ADDRSIZE:ADDRSIZE-1], w_wq_rptr[ADDRSIZE-2:0]};
    assign w_diff      = w_wbinnext - w_rbin_s;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        w_rbin_s = '0;
        for (int i = 0; i <= ADDRSIZE; i++) begin
            w_rbin_s[i] = ^(w_wq_rptr >> i);
        end
    end

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            r_wbin         <= '0;
            r_wptr         <= '0;
            r_wfill        <= '0;
            r_wfull        <= 1'b0;
            r_walmost_full <= 1'b0;
            r_woverflow    <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_wbin         <= w_wbinnext;
            r_wptr         <= w_wgraynext;
            r_wfill        <= w_diff;
            r_wfull        <= (w_wgraynext == w_fullcmp);
            r_walmost_full <= (w_diff >= AFULL_CMP);
            // A dropped write in the same cycle as a clear keeps the flag set.
            if (winc && r_wfull) begin
                r_woverflow <= 1'b1;
            end else if (wovf_clr) begin
                r_woverflow <= 1'b0;
            end
            r_sync[0] <= rptr;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign waddr        = r_wbin[ADDRSIZE-1:0];
    assign wptr         = r_wptr;
    assign wfull        = r_wfull;
    assign walmost_full = r_walmost_full;
    assign wfill        = r_wfill;
    assign woverflow    = r_woverflow;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Scoreboard bench for wptr_full_ctrl: a count-based reference model pushes expected outputs per edge,
// and a monitor pops and compares them on the following falling edge.
module tb_wptr_full_ctrl;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int PMOD  = 32;
    localparam int AFL   = 12;
    localparam int SS    = 2;

    logic          wclk = 1'b0;
    logic          wrst_n = 1'b0;
    logic          winc = 1'b0;
    logic          wovf_clr = 1'b0;
    logic [AW:0]   rptr = '0;
    logic [AW-1:0] waddr;
    logic [AW:0]   wptr;
    logic          wfull;
    logic          walmost_full;
    logic [AW:0]   wfill;
    logic          woverflow;

    wptr_full_ctrl #(.ADDRSIZE(AW), .AFULL_LEVEL(AFL), .SYNC_STAGES(SS)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .rptr(rptr), .wovf_clr(wovf_clr),
        .waddr(waddr), .wptr(wptr), .wfull(wfull), .walmost_full(walmost_full),
        .wfill(wfill), .woverflow(woverflow)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        int addr;
        int ptr;
        int full;
        int almost;
        int fill;
        int ovf;
    } expect_t;

    expect_t expQ[$];
    int      hist[$];
    int      wCount = 0;
    int      rCount = 0;
    int      ovfModel = 0;
    int      fullModel = 0;
    int      total = 0;
    int      bad = 0;

    function automatic int toGray(input int n);
        int b;
        b = n % PMOD;
        return b ^ (b >> 1);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Called on a falling edge; drives one cycle, models the rising edge, returns on the next falling edge.
    task automatic applyStimulus(input logic rstN, input logic inc, input logic clr, input logic doRead);
        expect_t e;
        int      used;
        int      fill;
        if (doRead && rCount < wCount) rCount++;
        wrst_n   = rstN;
        winc     = inc;
        wovf_clr = clr;
        rptr     = (AW+1)'(toGray(rCount));
        @(posedge wclk);
        if (!rstN) begin
            wCount = 0;
            rCount = 0;
            ovfModel = 0;
            fullModel = 0;
            hist = {};
            repeat (SS) hist.push_back(0);
            e = '{0, 0, 0, 0, 0, 0};
        end else begin
            hist.push_back(rCount);
            used = hist[0];
            void'(hist.pop_front());
            if (inc && fullModel != 0) ovfModel = 1;
            else if (clr) ovfModel = 0;
            if (inc && fullModel == 0) wCount++;
            fill = (wCount - used) % PMOD;
            fullModel = (fill == DEPTH) ? 1 : 0;
            e.addr   = wCount % DEPTH;
            e.ptr    = toGray(wCount);
            e.full   = fullModel;
            e.almost = (fill >= AFL) ? 1 : 0;
            e.fill   = fill;
            e.ovf    = ovfModel;
        end
        expQ.push_back(e);
        @(negedge wclk);
    endtask

    // Monitor: compare every modelled edge against the DUT once its outputs have settled.
    initial begin
        expect_t m;
        forever begin
            @(negedge wclk);
            if (expQ.size() > 0) begin
                m = expQ.pop_front();
                checkOutput("waddr",        32'(waddr),        m.addr);
                checkOutput("wptr",         32'(wptr),         m.ptr);
                checkOutput("wfull",        32'(wfull),        m.full);
                checkOutput("walmost_full", 32'(walmost_full), m.almost);
                checkOutput("wfill",        32'(wfill),        m.fill);
                checkOutput("woverflow",    32'(woverflow),    m.ovf);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          prevCount;
        logic [AW:0] prevPtr;
        bit          reached;
        repeat (SS) hist.push_back(0);
        @(negedge wclk);

        // Reset held with a write request and a nonzero read pointer.
        $display("[TB] reset");
        rCount = 2;
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("rstWptr", 32'(wptr), 0);
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("rstIdleFill", 32'(wfill), 0);

        // Fill all sixteen entries with the read pointer at zero.
        $display("[TB] fill");
        for (int i = 1; i <= 16; i++) begin
            checkOutput("fillAddr", 32'(waddr), i - 1);
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
            if (i == 12) begin
                checkOutput("afAt12", 32'(walmost_full), 1);
                checkOutput("fillAt12", 32'(wfill), 12);
            end
        end
        checkOutput("fullAt16", 32'(wfull), 1);
        checkOutput("ptrAt16", 32'(wptr), 32'h18);
        checkOutput("fillAt16", 32'(wfill), 16);
        checkOutput("addrAt16", 32'(waddr), 0);

        // Writes while full are dropped and set the sticky flag.
        $display("[TB] overflow");
        repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("ovfSet", 32'(woverflow), 1);
        checkOutput("ovfPtrHeld", 32'(wptr), 32'h18);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("ovfCleared", 32'(woverflow), 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("ovfSetWins", 32'(woverflow), 1);

        // One read: full must survive the synchroniser latency.
        $display("[TB] release");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("relEdge1", 32'(wfull), 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("relEdge2", 32'(wfull), 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("relEdge3", 32'(wfull), 0);
        checkOutput("relFill", 32'(wfill), 15);
        checkOutput("relAf", 32'(walmost_full), 1);

        // Stream through the pointer wrap until 36 writes against 20 reads.
        $display("[TB] wrap");
        reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            prevCount = wCount;
            prevPtr   = wptr;
            applyStimulus(1'b1, 1'b1, 1'b0, rCount < 20);
            checkOutput("grayStep", 32'($countones(wptr ^ prevPtr)), (wCount != prevCount) ? 1 : 0);
            if (wCount == 36) reached = 1'b1;
        end
        checkOutput("wrapReached", 32'(reached), 1);
        checkOutput("wrapFull", 32'(wfull), 1);
        checkOutput("wrapAddr", 32'(waddr), 4);

        // Drain to seven entries, then reset in the middle of a write.
        $display("[TB] mid reset");
        for (int i = 0; i < 100 && rCount < 29; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("midFill", 32'(wfill), 7);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("midRstAddr", 32'(waddr), 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("postRstAddr", 32'(waddr), 1);
        checkOutput("postRstFill", 32'(wfill), 1);

        // Random traffic, alternating read-heavy and write-heavy phases.
        $display("[TB] random");
        for (int i = 0; i < 3000; i++) begin
            int readPct;
            readPct = ((i / 300) % 2 == 0) ? 20 : 80;
            applyStimulus($urandom_range(0, 249) != 0,
                          $urandom_range(0, 99) < 70,
                          $urandom_range(0, 9) == 0,
                          $urandom_range(0, 99) < readPct);
        end

        @(negedge wclk);
        if (expQ.size() != 0) checkOutput("queueDrain", 32'(expQ.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
